// File: rtl/sort4_pkg.sv
// Shared definitions for the 4-byte sequential sorter.
//   state_e   : controller FSM states
//   N_ELEM    : number of byte elements in a set
//   STEP_LAST : index of the final compare/swap step
//   PAIR_IDX  : step -> lower index j of the compared pair (j, j+1)
package sort4_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSort,
    StDone
  } state_e;

  localparam int unsigned N_ELEM    = 4;
  localparam logic [2:0]  STEP_LAST = 3'd5;

  // Bubble passes over 4 elements: (0,1) (1,2) (2,3) | (0,1) (1,2) | (0,1).
  // Packed concatenation lists entry 5 first, entry 0 last.
  localparam logic [5:0][1:0] PAIR_IDX = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  // Out-of-range steps cannot occur; map them to pair 0 so the mux stays defined.
  function automatic logic [1:0] pair_idx(input logic [2:0] step);
    if (step <= STEP_LAST) begin
      return PAIR_IDX[step];
    end
    return 2'd0;
  endfunction

endpackage

// File: rtl/cmp_lt_8bit.sv
// 8-bit unsigned less-than comparator.
//   a, b : unsigned operands
//   lt   : 1 when a < b, taken as the borrow out of a - b
module cmp_lt_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       lt
);

  logic [8:0] diff;

  // Zero-extended subtract; bit 8 is the borrow.
  assign diff = {1'b0, a} - {1'b0, b};
  assign lt   = diff[8];

endmodule

// File: rtl/sort4_ctrl.sv
// Sequential sorter for a set of four unsigned bytes using one shared comparator.
// A set is captured on the input handshake, sorted with six fixed compare/swap
// steps (one per cycle), then presented until the consumer accepts it.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : in_data holds a set
//   in_ready  : a set is accepted this cycle (IDLE only)
//   in_data   : element k = in_data[8k+7:8k]
//   out_valid : out_data holds the sorted set (DONE only)
//   out_ready : consumer accepts out_data
//   out_data  : element 0 smallest (DESCEND=0) or largest (DESCEND=1)
//   busy      : high while sorting
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter bit DESCEND = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_e                    state_q, state_d;
  logic [2:0]                step_q, step_d;
  logic [N_ELEM-1:0][7:0]    elem_q, elem_d;

  logic [1:0] lo_idx;
  logic [1:0] hi_idx;
  logic [7:0] lo_val;
  logic [7:0] hi_val;
  logic [7:0] cmp_a;
  logic [7:0] cmp_b;
  logic       cmp_lt;

  assign lo_idx = pair_idx(step_q);
  assign hi_idx = lo_idx + 2'd1;
  assign lo_val = elem_q[lo_idx];
  assign hi_val = elem_q[hi_idx];

  // Ascending swaps when the upper element is smaller; descending when the
  // lower element is smaller. Equal values never swap in either order.
  assign cmp_a = DESCEND ? lo_val : hi_val;
  assign cmp_b = DESCEND ? hi_val : lo_val;

  cmp_lt_8bit u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cmp_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      elem_q  <= elem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    elem_d  = elem_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          elem_d  = in_data;
          step_d  = 3'd0;
          state_d = StSort;
        end
      end

      StSort: begin
        if (cmp_lt) begin
          elem_d[lo_idx] = hi_val;
          elem_d[hi_idx] = lo_val;
        end
        if (step_q == STEP_LAST) begin
          step_d  = 3'd0;
          state_d = StDone;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        step_d  = 3'd0;
      end
    endcase
  end

  // Gated by rst so no set is advertised as accepted while reset is held.
  assign in_ready  = (state_q == StIdle) & ~rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StSort);
  assign out_data  = elem_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
module tb_sort4_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [31:0] out_data_a;
  logic        in_ready_d, out_valid_d, busy_d;
  logic [31:0] out_data_d;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_d_q[$];

  sort4_ctrl #(.DESCEND(1'b0)) dut_asc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .busy      (busy_a)
  );

  sort4_ctrl #(.DESCEND(1'b1)) dut_desc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_d),
    .in_data   (in_data),
    .out_valid (out_valid_d),
    .out_ready (out_ready),
    .out_data  (out_data_d),
    .busy      (busy_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: each byte goes to its rank position; ties broken by input index.
  function automatic logic [31:0] ref_sort(input logic [31:0] data, input bit desc);
    logic [7:0] e [4];
    logic [31:0] res;
    int rank;
    for (int i = 0; i < 4; i++) e[i] = data[8*i +: 8];
    res = '0;
    for (int i = 0; i < 4; i++) begin
      rank = 0;
      for (int j = 0; j < 4; j++) begin
        if (desc) begin
          if (e[j] > e[i] || (e[j] == e[i] && j < i)) rank++;
        end else begin
          if (e[j] < e[i] || (e[j] == e[i] && j < i)) rank++;
        end
      end
      res[8*rank +: 8] = e[i];
    end
    return res;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_a_q.delete();
      exp_d_q.delete();
    end else begin
      if (in_valid && in_ready_a) exp_a_q.push_back(ref_sort(in_data, 1'b0));
      if (in_valid && in_ready_d) exp_d_q.push_back(ref_sort(in_data, 1'b1));
      if (out_valid_a && out_ready) begin
        n_pop++;
        if (exp_a_q.size() == 0) check_eq("asc_unexpected_out", out_data_a, 32'hxxxxxxxx);
        else check_eq("asc_data", out_data_a, exp_a_q.pop_front());
      end
      if (out_valid_d && out_ready) begin
        if (exp_d_q.size() == 0) check_eq("desc_unexpected_out", out_data_d, 32'hxxxxxxxx);
        else check_eq("desc_data", out_data_d, exp_d_q.pop_front());
      end
    end
  end

  task automatic wait_in_ready();
    int k = 0;
    while (!in_ready_a && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("in_ready_wait", {31'd0, in_ready_a}, 32'd1);
  endtask

  task automatic wait_out_valid(output int k);
    k = 0;
    while (!out_valid_a && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Directed set with out_ready held high: checks latency and exact results.
  task automatic send_set(input logic [31:0] data, input logic [31:0] ea, input logic [31:0] ed);
    int k;
    out_ready = 1'b1;
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("busy_after_accept", {31'd0, busy_a}, 32'd1);
    wait_out_valid(k);
    check_eq("latency", k, 32'd6);
    check_eq("desc_valid_aligned", {31'd0, out_valid_d}, 32'd1);
    check_eq("asc_const", out_data_a, ea);
    check_eq("desc_const", out_data_d, ed);
    @(posedge clk); #1;
    check_eq("idle_after_out", {30'd0, in_ready_a, out_valid_a}, 32'd2);
  endtask

  initial begin
    int k;
    logic seen;
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check_eq("rst_flags", {29'd0, out_valid_a, busy_a, out_valid_d}, 32'd0);
    check_eq("rst_out_data", out_data_a, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("in_ready_after_rst", {31'd0, in_ready_a}, 32'd1);

    send_set(32'h01020304, 32'h04030201, 32'h01020304);
    send_set(32'h00FF7F80, 32'hFF807F00, 32'h007F80FF);
    send_set(32'h55555555, 32'h55555555, 32'h55555555);
    send_set(32'h40302010, 32'h40302010, 32'h10203040);

    // Stall in DONE with a new set waiting on the input.
    out_ready = 1'b0;
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 32'h11334422;
    @(posedge clk); #1;
    in_data  = 32'hA0B0C0D0;
    wait_out_valid(k);
    check_eq("stall_latency", k, 32'd6);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall_state", {29'd0, out_valid_a, in_ready_a, busy_a}, 32'd4);
      check_eq("stall_data", out_data_a, 32'h44332211);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_release", {31'd0, in_ready_a}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("next_accepted", {31'd0, busy_a}, 32'd1);
    wait_out_valid(k);
    check_eq("next_latency", k, 32'd6);
    check_eq("next_data", out_data_a, 32'hD0C0B0A0);
    @(posedge clk); #1;

    // Reset pulsed mid-sort at step 3.
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 32'h99887766;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check_eq("midrst_busy", {30'd0, busy_a, out_valid_a}, 32'd0);
    check_eq("midrst_data", out_data_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_d) seen = 1'b1;
    end
    check_eq("no_valid_after_rst", {31'd0, seen}, 32'd0);
    check_eq("ready_after_midrst", {31'd0, in_ready_a}, 32'd1);
    check_eq("data_after_midrst", out_data_a, 32'd0);
    send_set(32'h0A0B0C01, 32'h0C0B0A01, 32'h010A0B0C);

    // Back-to-back random sets with random out_ready.
    n_pop = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      if (i % 10 == 0) in_data = {in_data[7:0], in_data[7:0], in_data[23:8]};
      k = 0;
      acc = 1'b0;
      while (!acc && k < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        acc = in_ready_a;
        @(posedge clk); #1;
        k++;
      end
      if (!acc) check_eq("rand_accept_timeout", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    k = 0;
    while ((exp_a_q.size() != 0 || exp_d_q.size() != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("drain_asc", exp_a_q.size(), 32'd0);
    check_eq("drain_desc", exp_d_q.size(), 32'd0);
    check_eq("rand_out_count", n_pop, 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL have parameter DESCEND, default 0, meaning 0 = ascending output order and 1 = descending output order.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  in_data holds a valid 4-byte set.
REQ-005 SHALL have port in_ready  output  1  block accepts a set this cycle.
REQ-006 SHALL have port in_data  input  32  four unsigned bytes; element k = in_data[8k+7:8k].
REQ-007 SHALL have port out_valid  output  1  out_data holds a sorted set.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 SHALL have port out_data  output  32  sorted bytes; element 0 = smallest (DESCEND=0) or largest (DESCEND=1).
REQ-010 SHALL have port busy  output  1  high while in SORT state.

Function
REQ-011 SHALL implement FSM states IDLE, SORT, DONE.
REQ-012 SHALL assert in_ready only in IDLE; input handshake = in_valid & in_ready.
REQ-013 On input handshake SHALL capture in_data into a 4x8 element register, clear step counter to 0, and go IDLE->SORT.
REQ-014 SHALL share exactly one 8-bit unsigned less-than comparator (borrow out of a - b) among all compare steps, one compare per cycle.
REQ-015 Step counter (3 bits) SHALL select pairs: step0 (0,1), step1 (1,2), step2 (2,3), step3 (0,1), step4 (1,2), step5 (0,1).
REQ-016 Per step, for pair (j,j+1): DESCEND=0 swap iff e[j+1] < e[j]; DESCEND=1 swap iff e[j] < e[j+1]; equal values never swap.
REQ-017 After step5 edge SHALL go SORT->DONE; fixed latency: out_valid high exactly 6 cycles after the input-handshake edge, independent of data.
REQ-018 out_valid SHALL be high only in DONE; out_data = element register, held stable while out_valid=1 and out_ready=0.
REQ-019 On output handshake (out_valid & out_ready) SHALL go DONE->IDLE; in_ready rises the following cycle (no same-cycle reload).
REQ-020 in_valid while in SORT or DONE SHALL be ignored with no state change.
REQ-021 out_ready while not in DONE SHALL have no effect.
REQ-022 busy SHALL equal (state == SORT).
REQ-023 Step counter SHALL not increment outside SORT and SHALL never exceed 5.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, step counter 0, element register 0, out_valid 0, busy 0, in_ready 1 while rst low thereafter.
REQ-025 rst asserted mid-SORT or in DONE SHALL discard the set in progress; no out_valid follows for it.
REQ-026 in_ready SHALL be 0 while rst=1.

Structure
REQ-027 Package sort4_pkg SHALL hold the state enum, N_ELEM=4, STEP_LAST=5, and the step-to-pair-index table.
REQ-028 Comparator SHALL be sub-module cmp_lt_8bit (inputs a, b [7:0]; output lt = borrow out), instantiated once; operands muxed by step.
REQ-029 Swap, mux, and FSM logic SHALL reside in sort4_ctrl.

Verification
REQ-030 in_data=32'h01020304, DESCEND=0, out_ready=1 -> out_valid exactly 6 cycles after accept, out_data=32'h04030201.
REQ-031 in_data=32'h00FF7F80 (boundary values) -> out_data=32'hFF807F00; DESCEND=1 same input -> 32'h007F80FF.
REQ-032 in_data=32'h55555555 and already-sorted 32'h40302010 -> output equals input, latency still 6.
REQ-033 out_ready=0 for 10 cycles in DONE while in_valid=1 with new data -> out_data stable, in_ready=0, new data not captured; after out_ready=1 next set accepted one cycle later.
REQ-034 rst pulsed at step 3 of a sort -> out_valid never asserts for that set, out_data=0, in_ready=1 after release; next set sorts correctly.
REQ-035 Back-to-back 100 random sets with random out_ready -> every output equals reference sort of its input, in order, none lost or duplicated.
